ptc_code_encoder: RTL and testbench
===================================

// Module: ptc_code_encoder
// PURPOSE
//  Inverse of the PTC coarse decoder. Samples the 16-bit coarse one-hot select
//  and the 6-bit fine code driving the phase tuning cell, and rebuilds the
//  10-bit control word Q. Filters for stability and flags illegal selects.
//  Used for DLL lock readback and by the calibration FSM for code verification.
// PARAMETERS
//  SYNC_STAGES    2   synchroniser depth on t_in/fine_in (>=2)
//  STABLE_CYCLES  4   consecutive matching samples required before result (>=1)
//  MAX_RETRY      15  mismatch restarts allowed before timeout (>=1)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   reset, synchronous, active-low
//  t_in       in   16  coarse select from PTC domain (asynchronous)
//  fine_in    in   6   fine code from PTC domain (asynchronous)
//  start      in   1   request one encode; honoured only in IDLE
//  q_ready    in   1   consumer accepts q_out when q_valid=1
//  busy       out  1   1 in SETTLE or HOLD
//  q_valid    out  1   result (or error) available; held until q_ready
//  q_out      out  10  {coarse[3:0], fine[5:0]}
//  err_code   out  2   00 ok, 01 multi-hot, 10 bit15 set, 11 timeout
// BEHAVIOUR
//  Reset: when rst_n=0 at a clk edge, the FSM goes to IDLE and all sync flops,
//   the snapshot, and the counters clear. busy, q_valid, q_out and err_code all
//   reset to 0. Reset applies in any state; a transfer in progress is dropped.
//  Sync: t_in and fine_in each pass through SYNC_STAGES flops. s_t and s_f are
//   the synchronised values. All checks below use s_t and s_f.
//  Coarse map (exact inverse of the decoder):
//   - s_t==0 -> coarse 0.
//   - Only bit k set, k=0..14 -> coarse k+1.
//   - Bit 15 set -> err 10 (takes priority over multi-hot).
//   - More than one bit set -> err 01.
//  FSM IDLE/SETTLE/HOLD:
//   IDLE: when start=1, snap<={s_t,s_f}, cnt<=0, retry<=0, then go to SETTLE.
//   SETTLE: each cycle, compare {s_t,s_f} with snap.
//    - Equal: cnt++. When cnt reaches STABLE_CYCLES, encode snap, load q_out and
//      err_code, set q_valid=1, and go to HOLD.
//    - Not equal: snap<=new value, cnt<=0, retry++.
//    - If retry reaches MAX_RETRY on a mismatch: q_out<=0, err_code<=11,
//      q_valid=1, go to HOLD.
//   HOLD: q_out, err_code and q_valid stay stable. When q_valid&q_ready, clear
//    q_valid and go to IDLE. q_out and err_code keep their last values.
//  Error results: if err_code!=00 after encoding, coarse is forced to 0 and
//   fine is still reported.
//  Latency: with inputs stable for at least SYNC_STAGES cycles, q_valid rises
//   STABLE_CYCLES+1 cycles after the clk edge that samples start=1.
//  Simultaneous events:
//   - start while busy is ignored and not queued.
//   - start in the same cycle as the HOLD handshake is ignored; start must be
//     re-asserted in IDLE.
//   - q_ready outside HOLD has no effect.
//  A mismatch on the same cycle the count would complete counts as a mismatch.
// TESTING
//  1 Reset: drive rst_n=0 mid-SETTLE -> next cycle busy=0, q_valid=0, q_out=0,
//    err_code=0, FSM in IDLE.
//  2 Encode sweep: for each code c=0..15, set t_in=decoder(c) and fine_in=6'h2A,
//    then pulse start. Expect q_out={c,6'h2A} and err_code=00, with q_valid
//    rising STABLE_CYCLES+1 cycles after start. Keep q_ready low for 3 cycles
//    and check that q_out is held.
//  3 Illegal select: t_in=16'h0005 -> err 01 and q_out[9:6]=0.
//    t_in=16'h8000 -> err 10. t_in=16'h8001 -> err 10.
//  4 Glitch: toggle fine_in once during SETTLE -> cnt restarts. Result reflects
//    the new value and latency grows by the restart offset.
//  5 Timeout: toggle t_in every cycle -> after MAX_RETRY mismatches,
//    err_code=11 and q_out=0.
//  6 Handshake corner: hold start=1 continuously with q_ready=1 -> exactly one
//    result per IDLE visit, and no back-to-back result in the handshake cycle.

Source files
------------

// File: rtl/ptc_code_encoder.sv
// Rebuilds the 10-bit PTC control word from the synchronised coarse one-hot and fine code.
// Result after STABLE_CYCLES+1 stable samples following start; held in HOLD until q_ready.
module ptc_code_encoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_RETRY     = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] t_in,
  input  logic [5:0]  fine_in,
  input  logic        start,
  input  logic        q_ready,
  output logic        busy,
  output logic        q_valid,
  output logic [9:0]  q_out,
  output logic [1:0]  err_code
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t                          state, state_nxt;
  logic [SYNC_STAGES-1:0][21:0]    sync_pipe;
  logic [21:0]                     s_tf;
  logic [21:0]                     snap, snap_nxt;
  logic [15:0]                     snap_t;
  logic [CW-1:0]                   cnt, cnt_nxt;
  logic [RW-1:0]                   retry, retry_nxt;
  logic                            valid_nxt;
  logic [9:0]                      q_nxt;
  logic [1:0]                      err_nxt;
  logic [3:0]                      enc_coarse;
  logic [1:0]                      enc_err;
  logic                            multi_hot;

  // {t_in, fine_in} travel together so one snapshot compare covers both
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], {t_in, fine_in}};
    end
  end

  assign s_tf   = sync_pipe[SYNC_STAGES-1];
  assign snap_t = snap[21:6];
  assign busy   = (state != IDLE);

  always_comb begin
    enc_coarse = '0;
    enc_err    = 2'b00;
    for (int k = 0; k < 15; k++) begin
      if (snap_t[k]) enc_coarse = 4'(k + 1);
    end
    multi_hot = |(snap_t[14:0] & (snap_t[14:0] - 15'd1));
    if (snap_t[15]) begin
      enc_err    = 2'b10;
      enc_coarse = '0;
    end else if (multi_hot) begin
      enc_err    = 2'b01;
      enc_coarse = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    valid_nxt = q_valid;
    q_nxt     = q_out;
    err_nxt   = err_code;
    case (state)
      IDLE: begin
        if (start) begin
          snap_nxt  = s_tf;
          cnt_nxt   = '0;
          retry_nxt = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (s_tf == snap) begin
          if (cnt == CW'(STABLE_CYCLES)) begin
            q_nxt     = {enc_coarse, snap[5:0]};
            err_nxt   = enc_err;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else begin
          snap_nxt = s_tf;
          cnt_nxt  = '0;
          if (retry == RW'(MAX_RETRY - 1)) begin
            q_nxt     = '0;
            err_nxt   = 2'b11;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end else begin
            retry_nxt = retry + RW'(1);
          end
        end
      end
      HOLD: begin
        if (q_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      snap     <= '0;
      cnt      <= '0;
      retry    <= '0;
      q_valid  <= 1'b0;
      q_out    <= '0;
      err_code <= 2'b00;
    end else begin
      state    <= state_nxt;
      snap     <= snap_nxt;
      cnt      <= cnt_nxt;
      retry    <= retry_nxt;
      q_valid  <= valid_nxt;
      q_out    <= q_nxt;
      err_code <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ptc_code_encoder.sv
// Directed bench for ptc_code_encoder with a history-based reference model checked every cycle.
module tb_ptc_code_encoder;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;
  localparam int MAXR   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] t_in = '0;
  logic [5:0]  fine_in = '0;
  logic        start = 1'b0;
  logic        q_ready = 1'b0;
  logic        busy, q_valid;
  logic [9:0]  q_out;
  logic [1:0]  err_code;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  ptc_code_encoder #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst_n(rst_n), .t_in(t_in), .fine_in(fine_in), .start(start),
    .q_ready(q_ready), .busy(busy), .q_valid(q_valid), .q_out(q_out), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic void encode_ref(input logic [21:0] v, output logic [9:0] q, output logic [1:0] e);
    logic [15:0] t;
    logic [3:0]  c;
    t = v[21:6];
    c = 4'd0;
    e = 2'b00;
    if (t[15]) e = 2'b10;
    else if ($countones(t) > 1) e = 2'b01;
    else if (t != 16'h0) c = 4'($clog2(t) + 1);
    q = {c, v[5:0]};
  endfunction

  // Reference: inputs seen through a SYNC-deep delay queue; after start, the
  // sample history decides completion (run of STABLE+1 repeats) or timeout.
  logic [21:0] pipe_q[$];
  logic [21:0] hist[$];
  int          m_mode = 0;
  logic        m_valid = 1'b0;
  logic [9:0]  m_q = '0;
  logic [1:0]  m_err = 2'b00;

  always @(posedge clk) begin
    logic [21:0] s_now;
    int changes, last;
    if (!rst_n) begin
      pipe_q = {};
      repeat (SYNC) pipe_q.push_back(22'h0);
      hist = {};
      m_mode = 0; m_valid = 1'b0; m_q = '0; m_err = 2'b00;
    end else begin
      s_now = pipe_q.pop_front();
      pipe_q.push_back({t_in, fine_in});
      if (m_mode == 0) begin
        if (start) begin
          hist = {};
          hist.push_back(s_now);
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        hist.push_back(s_now);
        changes = 0; last = 0;
        for (int i = 1; i < hist.size(); i++)
          if (hist[i] != hist[i-1]) begin changes++; last = i; end
        if (changes == MAXR) begin
          m_q = '0; m_err = 2'b11; m_valid = 1'b1; m_mode = 2;
        end else if (hist.size() - 1 - last == STABLE + 1) begin
          encode_ref(hist[last], m_q, m_err);
          m_valid = 1'b1; m_mode = 2;
        end
      end else if (q_ready) begin
        m_valid = 1'b0; m_mode = 0;
      end
    end
  end

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 32'(busy), 32'(m_mode != 0));
      check("model_valid", 32'(q_valid), 32'(m_valid));
      check("model_q", 32'(q_out), 32'(m_q));
      check("model_err", 32'(err_code), 32'(m_err));
    end
  end

  task automatic settle(input logic [15:0] t, input logic [5:0] f);
    t_in = t; fine_in = f;
    repeat (SYNC + 1) @(negedge clk);
  endtask

  task automatic wait_valid(inout int lat);
    while (!q_valid && lat < 100) begin @(negedge clk); lat++; end
    if (!q_valid) check("wait_valid_timeout", 32'(lat), 32'd0);
  endtask

  task automatic run_one(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    wait_valid(lat);
  endtask

  task automatic release_result();
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
    check("released_valid", 32'(q_valid), 32'd0);
  endtask

  initial begin
    int lat, rises, last_rise;
    logic [15:0] tv;
    logic [9:0]  held;
    bit prev_v;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(q_valid), 32'd0);
    check("rst_q", 32'(q_out), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    rst_n = 1'b1;

    // encode sweep with held output under backpressure
    for (int c = 0; c < 16; c++) begin
      tv = (c == 0) ? 16'h0 : (16'h1 << (c - 1));
      settle(tv, 6'h2A);
      run_one(lat);
      check("sweep_lat", 32'(lat), 32'(STABLE + 1));
      check("sweep_q", 32'(q_out), 32'({c[3:0], 6'h2A}));
      check("sweep_err", 32'(err_code), 32'd0);
      held = q_out;
      repeat (3) @(negedge clk);
      check("sweep_hold_valid", 32'(q_valid), 32'd1);
      check("sweep_hold_q", 32'(q_out), 32'(held));
      release_result();
    end

    settle(16'h0005, 6'h2A);
    run_one(lat);
    check("multi_err", 32'(err_code), 32'd1);
    check("multi_q", 32'(q_out), 32'h02A);
    release_result();
    settle(16'h8000, 6'h15);
    run_one(lat);
    check("b15_err", 32'(err_code), 32'd2);
    check("b15_q", 32'(q_out), 32'h015);
    release_result();
    settle(16'h8001, 6'h15);
    run_one(lat);
    check("b15multi_err", 32'(err_code), 32'd2);
    check("b15multi_q", 32'(q_out), 32'h015);
    release_result();

    // glitch on fine code one cycle into SETTLE: restart adds 4 cycles
    settle(16'h0008, 6'h11);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    fine_in = 6'h22;
    lat = 1;
    wait_valid(lat);
    check("glitch_lat", 32'(lat), 32'd9);
    check("glitch_q", 32'(q_out), 32'({4'd4, 6'h22}));
    check("glitch_err", 32'(err_code), 32'd0);
    release_result();

    // timeout: coarse select toggles every cycle
    settle(16'h0001, 6'h07);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!q_valid && lat < 100) begin
      t_in = (t_in == 16'h0001) ? 16'h0002 : 16'h0001;
      @(negedge clk);
      lat++;
    end
    check("timeout_lat", 32'(lat), 32'd17);
    check("timeout_err", 32'(err_code), 32'd3);
    check("timeout_q", 32'(q_out), 32'd0);
    release_result();

    // start held with q_ready held: one result per IDLE visit
    settle(16'h0010, 6'h3C);
    q_ready = 1'b1;
    start = 1'b1;
    rises = 0; last_rise = 0; prev_v = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q_valid) begin
        if (prev_v) check("back_to_back", 32'd1, 32'd0);
        if (rises > 0) check("hs_gap", 32'(i - last_rise), 32'(STABLE + 3));
        else check("hs_first", 32'(i), 32'(STABLE + 1));
        rises++;
        last_rise = i;
      end
      prev_v = q_valid;
    end
    check("hs_rises", 32'(rises), 32'd5);
    start = 1'b0;
    repeat (10) @(negedge clk);
    q_ready = 1'b0;

    // reset mid-SETTLE after a nonzero result
    settle(16'h0400, 6'h01);
    run_one(lat);
    release_result();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(q_valid), 32'd0);
    check("mid_rst_q", 32'(q_out), 32'd0);
    check("mid_rst_err", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
